// File: rtl/multicycle_ctrl_pkg.sv
// Shared CPU defines: opcode/funct constants plus the control encodings used by
// the multi-cycle controller and its decoder.
package multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_XOR = 2'd2, ALU_SLT = 2'd3} alu_op_t;
  typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_BRANCH = 2'd1, PC_JUMP = 2'd2, PC_RS = 2'd3} pc_src_t;
  typedef enum logic [1:0] {DST_RT = 2'd0, DST_RD = 2'd1, DST_R31 = 2'd2} reg_dst_t;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC = 2'd2} wb_sel_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  // Instruction class latched in DECODE; CL_NONE marks an unsupported encoding.
  typedef enum logic [3:0] {
    CL_NONE = 4'd0,
    CL_ADD  = 4'd1,
    CL_SUB  = 4'd2,
    CL_SLT  = 4'd3,
    CL_ADDI = 4'd4,
    CL_XORI = 4'd5,
    CL_LW   = 4'd6,
    CL_SW   = 4'd7,
    CL_BEQ  = 4'd8,
    CL_BNE  = 4'd9,
    CL_J    = 4'd10,
    CL_JAL  = 4'd11,
    CL_JR   = 4'd12
  } class_t;

  function automatic logic is_rtype_alu(input class_t c);
    return (c == CL_ADD) || (c == CL_SUB) || (c == CL_SLT);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational opcode/funct classifier for the multi-cycle controller.
module ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] cls,
  output logic       illegal
);

  class_t c;

  // NOTE: assign a default before the case so every path drives c and no latch is inferred.
  always_comb begin
    c = CL_NONE;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  c = CL_ADD;
          FN_SUB:  c = CL_SUB;
          FN_SLT:  c = CL_SLT;
          FN_JR:   c = CL_JR;
          default: c = CL_NONE;
        endcase
      end
      OP_J:    c = CL_J;
      OP_JAL:  c = CL_JAL;
      OP_BEQ:  c = CL_BEQ;
      OP_BNE:  c = CL_BNE;
      OP_ADDI: c = CL_ADDI;
      OP_XORI: c = CL_XORI;
      OP_LW:   c = CL_LW;
      OP_SW:   c = CL_SW;
      default: c = CL_NONE;
    endcase
  end

  assign cls     = c;
  assign illegal = (c == CL_NONE);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset CPU: sequences fetch, decode,
// execute, memory and writeback and counts retired instructions.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             pc_wr,
  output logic [1:0]       pc_src,
  output logic             ir_wr,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [1:0]       alu_op,
  output logic             alu_src_b,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_sel,
  output logic             regwr,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  state_t     cur, nxt;
  class_t     cls_q;
  logic [3:0] dec_cls_raw;
  logic       dec_illegal;
  logic       branch_taken;

  ctrl_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (dec_cls_raw),
    .illegal (dec_illegal)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_IDLE;
    else        cur <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cls_q <= CL_NONE;
    else if (cur == S_DECODE)  cls_q <= class_t'(dec_cls_raw);
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH:  if (mem_ready) nxt = S_DECODE;
      S_DECODE: nxt = dec_illegal ? S_FETCH : S_EXEC;
      S_EXEC: begin
        case (cls_q)
          CL_ADD, CL_SUB, CL_SLT, CL_ADDI, CL_XORI: nxt = S_WB;
          CL_LW, CL_SW:                             nxt = S_MEM;
          default:                                  nxt = S_FETCH;
        endcase
      end
      S_MEM:    if (mem_ready) nxt = (cls_q == CL_LW) ? S_WB : S_FETCH;
      S_WB:     nxt = S_FETCH;
      default:  nxt = S_IDLE;
    endcase
  end

  // BEQ branches on zero, BNE on non-zero.
  assign branch_taken = alu_zero ~^ (cls_q == CL_BEQ);

  always_comb begin
    pc_wr      = 1'b0;
    pc_src     = PC_PLUS4;
    ir_wr      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    alu_op     = ALU_ADD;
    alu_src_b  = 1'b0;
    reg_dst    = DST_RT;
    wb_sel     = WB_ALU;
    regwr      = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_wr = 1'b1;
          pc_wr = 1'b1;
        end
      end
      S_DECODE: illegal = dec_illegal;
      S_EXEC: begin
        case (cls_q)
          CL_SUB:                 alu_op = ALU_SUB;
          CL_SLT:                 alu_op = ALU_SLT;
          CL_ADDI, CL_LW, CL_SW:  alu_src_b = 1'b1;
          CL_XORI: begin
            alu_op    = ALU_XOR;
            alu_src_b = 1'b1;
          end
          CL_BEQ, CL_BNE: begin
            alu_op     = ALU_SUB;
            instr_done = 1'b1;
            if (branch_taken) begin
              pc_wr  = 1'b1;
              pc_src = PC_BRANCH;
            end
          end
          CL_J: begin
            pc_wr      = 1'b1;
            pc_src     = PC_JUMP;
            instr_done = 1'b1;
          end
          // Link and jump share one edge; the datapath's PC is still PC+4 here.
          CL_JAL: begin
            pc_wr      = 1'b1;
            pc_src     = PC_JUMP;
            regwr      = 1'b1;
            reg_dst    = DST_R31;
            wb_sel     = WB_PC;
            instr_done = 1'b1;
          end
          CL_JR: begin
            pc_wr      = 1'b1;
            pc_src     = PC_RS;
            instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (cls_q == CL_LW) mem_rd = 1'b1;
        if (cls_q == CL_SW) begin
          mem_wr     = 1'b1;
          instr_done = mem_ready;
        end
      end
      S_WB: begin
        regwr      = 1'b1;
        instr_done = 1'b1;
        if (is_rtype_alu(cls_q)) reg_dst = DST_RD;
        if (cls_q == CL_LW)      wb_sel  = WB_MEM;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          retired <= '0;
    else if (instr_done) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign state = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and randomized instructions
// compared cycle by cycle against a per-instruction sequence model.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [5:0]       opcode, funct;
  logic             alu_zero, mem_ready;
  logic             pc_wr, ir_wr, mem_rd, mem_wr, alu_src_b, regwr, instr_done, illegal;
  logic [1:0]       pc_src, alu_op, reg_dst, wb_sel;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .alu_zero   (alu_zero),
    .mem_ready  (mem_ready),
    .pc_wr      (pc_wr),
    .pc_src     (pc_src),
    .ir_wr      (ir_wr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .alu_op     (alu_op),
    .alu_src_b  (alu_src_b),
    .reg_dst    (reg_dst),
    .wb_sel     (wb_sel),
    .regwr      (regwr),
    .instr_done (instr_done),
    .illegal    (illegal),
    .retired    (retired),
    .state      (state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       ir_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] alu_op;
    logic       alu_src_b;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic       regwr;
    logic       instr_done;
    logic       illegal;
  } outs_t;

  typedef enum {K_ADD, K_SUB, K_SLT, K_ADDI, K_XORI, K_LW, K_SW,
                K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_BAD} kind_t;

  int               n_cmp  = 0;
  int               n_fail = 0;
  logic [CNT_W-1:0] ret_m;

  function automatic outs_t observed();
    outs_t o;
    o = '{state, pc_wr, pc_src, ir_wr, mem_rd, mem_wr, alu_op, alu_src_b,
          reg_dst, wb_sel, regwr, instr_done, illegal};
    return o;
  endfunction

  function automatic outs_t blank(input logic [2:0] st);
    outs_t o;
    o    = '0;
    o.st = st;
    return o;
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        case (fn)
          6'h20:   return K_ADD;
          6'h22:   return K_SUB;
          6'h2A:   return K_SLT;
          6'h08:   return K_JR;
          default: return K_BAD;
        endcase
      end
      6'h02:   return K_J;
      6'h03:   return K_JAL;
      6'h04:   return K_BEQ;
      6'h05:   return K_BNE;
      6'h08:   return K_ADDI;
      6'h0E:   return K_XORI;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      default: return K_BAD;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, compare just after.
  task automatic cycle(input string tag, input outs_t exp, input logic mr, input logic az,
                       input logic [5:0] op, input logic [5:0] fn);
    @(negedge clk);
    mem_ready = mr;
    alu_zero  = az;
    opcode    = op;
    funct     = fn;
    #1;
    check(tag, 32'(observed()), 32'(exp));
    check({tag, "_retired"}, 32'(retired), 32'(ret_m));
    if (exp.instr_done) ret_m++;
  endtask

  // Runs one instruction; wf/wm are memory wait cycles in fetch and in the data access.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input int wf, input int wm, input logic az_exec);
    kind_t k;
    outs_t o;
    logic  taken;
    k = classify(op, fn);

    o = blank(S_FETCH);
    o.mem_rd = 1'b1;
    for (int i = 0; i < wf; i++) cycle({tag, "_fetchwait"}, o, 1'b0, rbit(), 6'($urandom), 6'($urandom));
    o.ir_wr = 1'b1;
    o.pc_wr = 1'b1;
    cycle({tag, "_fetch"}, o, 1'b1, rbit(), 6'($urandom), 6'($urandom));

    o = blank(S_DECODE);
    o.illegal = (k == K_BAD);
    cycle({tag, "_decode"}, o, rbit(), rbit(), op, fn);
    if (k == K_BAD) return;

    o = blank(S_EXEC);
    case (k)
      K_ADD:  o.alu_op = 2'd0;
      K_SUB:  o.alu_op = 2'd1;
      K_SLT:  o.alu_op = 2'd3;
      K_ADDI, K_LW, K_SW: o.alu_src_b = 1'b1;
      K_XORI: begin o.alu_op = 2'd2; o.alu_src_b = 1'b1; end
      K_BEQ, K_BNE: begin
        taken        = (k == K_BEQ) ? az_exec : !az_exec;
        o.alu_op     = 2'd1;
        o.pc_wr      = taken;
        o.pc_src     = taken ? 2'd1 : 2'd0;
        o.instr_done = 1'b1;
      end
      K_J:   begin o.pc_wr = 1'b1; o.pc_src = 2'd2; o.instr_done = 1'b1; end
      K_JAL: begin
        o.pc_wr = 1'b1; o.pc_src = 2'd2; o.regwr = 1'b1;
        o.reg_dst = 2'd2; o.wb_sel = 2'd2; o.instr_done = 1'b1;
      end
      K_JR:  begin o.pc_wr = 1'b1; o.pc_src = 2'd3; o.instr_done = 1'b1; end
      default: ;
    endcase
    cycle({tag, "_exec"}, o, rbit(), az_exec, op, fn);

    if (k == K_LW || k == K_SW) begin
      o = blank(S_MEM);
      o.mem_rd = (k == K_LW);
      o.mem_wr = (k == K_SW);
      for (int i = 0; i < wm; i++) cycle({tag, "_memwait"}, o, 1'b0, rbit(), op, fn);
      o.instr_done = (k == K_SW);
      cycle({tag, "_mem"}, o, 1'b1, rbit(), op, fn);
    end

    if (k inside {K_ADD, K_SUB, K_SLT, K_ADDI, K_XORI, K_LW}) begin
      o = blank(S_WB);
      o.regwr      = 1'b1;
      o.instr_done = 1'b1;
      o.reg_dst    = (k inside {K_ADD, K_SUB, K_SLT}) ? 2'd1 : 2'd0;
      o.wb_sel     = (k == K_LW) ? 2'd1 : 2'd0;
      cycle({tag, "_wb"}, o, rbit(), rbit(), op, fn);
    end
  endtask

  logic [5:0] op_pool [14];
  logic [5:0] fn_pool [6];

  initial begin
    op_pool = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
                6'h08, 6'h0E, 6'h23, 6'h2B, 6'h3F, 6'h01, 6'h00};
    fn_pool = '{6'h20, 6'h22, 6'h2A, 6'h08, 6'h21, 6'h00};
    rst_n = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0; opcode = '0; funct = '0;
    ret_m = '0;

    #1;
    check("reset_outs", 32'(observed()), 32'(blank(S_IDLE)));
    check("reset_retired", 32'(retired), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_after_release", 32'(observed()), 32'(blank(S_IDLE)));

    run_instr("add",        6'h00, 6'h20, 0, 0, 1'b0);
    run_instr("lw_wait3",   6'h23, 6'h15, 0, 3, 1'b0);
    run_instr("beq_taken",  6'h04, 6'h00, 0, 0, 1'b1);
    run_instr("beq_not",    6'h04, 6'h00, 0, 0, 1'b0);
    run_instr("bne_taken",  6'h05, 6'h00, 0, 0, 1'b0);
    run_instr("bne_not",    6'h05, 6'h00, 0, 0, 1'b1);
    run_instr("jal",        6'h03, 6'h00, 0, 0, 1'b0);
    run_instr("jr",         6'h00, 6'h08, 0, 0, 1'b0);
    run_instr("illegal_op", 6'h3F, 6'h00, 0, 0, 1'b0);
    run_instr("illegal_fn", 6'h00, 6'h21, 1, 0, 1'b0);
    run_instr("sub",        6'h00, 6'h22, 2, 0, 1'b1);
    run_instr("slt",        6'h00, 6'h2A, 0, 0, 1'b0);
    run_instr("addi",       6'h08, 6'h11, 0, 0, 1'b0);
    run_instr("xori",       6'h0E, 6'h3C, 0, 0, 1'b1);
    run_instr("sw_wait2",   6'h2B, 6'h00, 1, 2, 1'b0);
    run_instr("j",          6'h02, 6'h00, 0, 0, 1'b0);

    // Abandon an ADD in its writeback cycle with an asynchronous reset.
    run_instr("add_abort",  6'h00, 6'h20, 0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("reset_midwb_outs", 32'(observed()), 32'(blank(S_IDLE)));
    check("reset_midwb_retired", 32'(retired), 32'(0));
    ret_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_after_midwb", 32'(observed()), 32'(blank(S_IDLE)));

    for (int i = 0; i < 15; i++) run_instr("sw_wrap", 6'h2B, 6'($urandom), 0, 0, 1'b0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("retired_all_ones", 32'(retired), 32'(4'hF));
    run_instr("sw_wrap_last", 6'h2B, 6'($urandom), 0, 0, 1'b0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("retired_wrapped", 32'(retired), 32'(0));

    for (int n = 0; n < 80; n++) begin
      logic [5:0] op, fn;
      op = op_pool[$urandom_range(13, 0)];
      fn = (op == 6'h00) ? fn_pool[$urandom_range(5, 0)] : 6'($urandom);
      run_instr("rand", op, fn, int'($urandom_range(2, 0)), int'($urandom_range(3, 0)), rbit());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
